// File: rtl/kyp_scanner.sv
// kyp_scanner
//   Scans a 4x4 PmodKYP keypad and commits a debounced 4-bit hex key code.
//   One column is driven low per scan slot, and the active-low rows are
//   sampled at the end of each slot. One result is produced per 4-column
//   frame, and a key is committed only after DEBOUNCE_SCANS identical frames.
//
// Ports
//   clk        system clock
//   sys_rst_n  asynchronous active-low reset
//   row        keypad rows, active low, asynchronous to clk
//   col        column drive, active low, exactly one bit low
//   data       committed key code (0-F), holds its value across release
//   key_valid  high while a debounced key is held
//   key_press  one-cycle pulse on each newly committed key
//
// Parameters
//   SCAN_CYCLES     clk cycles per column slot (>= 4)
//   DEBOUNCE_SCANS  identical frames required to commit (>= 1)
module kyp_scanner #(
  parameter int unsigned SCAN_CYCLES    = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] data,
  output logic       key_valid,
  output logic       key_press
);

  localparam int unsigned SLOT_W = $clog2(SCAN_CYCLES);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_e;

  // Physical key position to hex code; index is {row, column}.
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Row synchroniser
  logic [3:0] row_meta_q, row_sync_q;

  // Column scan
  col_state_e          state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [3:0]          col_q, col_d;
  logic                tc;
  logic                frame_end;

  // Frame accumulator: pressed-key count saturating at 2 (2 = multiple keys)
  logic [1:0]          acc_cnt_q, acc_cnt_d;
  logic [3:0]          acc_code_q, acc_code_d;
  logic [2:0]          col_hits;
  logic [3:0]          col_code;
  logic [1:0]          hits_sat;
  logic [2:0]          hit_sum;
  logic [1:0]          frame_cnt;
  logic [3:0]          frame_code;

  // Debounce
  logic                cand_key_q, cand_key_d;   // 0 = NONE candidate, 1 = KEY
  logic [3:0]          cand_code_q, cand_code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                res_key, res_multi, res_same;
  logic                commit;

  // Outputs
  logic [3:0]          data_q, data_d;
  logic                key_valid_q, key_valid_d;
  logic                key_press_q, key_press_d;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  assign tc        = (slot_q == SLOT_W'(SCAN_CYCLES - 1));
  assign frame_end = tc && (state_q == COL3);

  // Column FSM: next state and next column drive
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q + SLOT_W'(1);
    if (tc) begin
      slot_d = '0;
      case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        COL2:    state_d = COL3;
        default: state_d = COL0;
      endcase
    end
    col_d          = '1;
    col_d[state_d] = 1'b0;
  end

  // Pressed keys in the active column, merged into the frame accumulator
  always_comb begin
    col_hits = '0;
    col_code = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_map(state_q, 2'(r));
      end
    end
    hits_sat   = (col_hits > 3'd1) ? 2'd2 : col_hits[1:0];
    hit_sum    = {1'b0, acc_cnt_q} + {1'b0, hits_sat};
    frame_cnt  = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
    // The first single key seen in the frame supplies the code.
    frame_code = (acc_cnt_q == 2'd0) ? col_code : acc_code_q;

    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (tc) begin
      if (state_q == COL3) begin
        acc_cnt_d  = '0;
        acc_code_d = '0;
      end else begin
        acc_cnt_d  = frame_cnt;
        acc_code_d = frame_code;
      end
    end
  end

  // Debounce and commit, evaluated on the frame's last sample
  always_comb begin
    res_key     = (frame_cnt == 2'd1);
    res_multi   = (frame_cnt == 2'd2);
    res_same    = (res_key == cand_key_q) && (!res_key || (frame_code == cand_code_q));

    cand_key_d  = cand_key_q;
    cand_code_d = cand_code_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;

    if (frame_end && !res_multi) begin
      if (res_same) begin
        // Saturation means only the first arrival at the threshold commits.
        if (cnt_q != CNT_W'(DEBOUNCE_SCANS)) begin
          cnt_d  = cnt_q + CNT_W'(1);
          commit = (cnt_d == CNT_W'(DEBOUNCE_SCANS));
        end
      end else begin
        cand_key_d  = res_key;
        cand_code_d = res_key ? frame_code : '0;
        cnt_d       = CNT_W'(1);
        commit      = (DEBOUNCE_SCANS == 1);
      end
    end

    data_d      = data_q;
    key_valid_d = key_valid_q;
    key_press_d = 1'b0;
    if (commit) begin
      if (res_key) begin
        data_d      = frame_code;
        key_valid_d = 1'b1;
        key_press_d = !key_valid_q || (data_q != frame_code);
      end else begin
        key_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= COL0;
      slot_q      <= '0;
      col_q       <= 4'b1110;
      acc_cnt_q   <= '0;
      acc_code_q  <= '0;
      cand_key_q  <= 1'b0;
      cand_code_q <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      key_valid_q <= 1'b0;
      key_press_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      col_q       <= col_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      cand_key_q  <= cand_key_d;
      cand_code_q <= cand_code_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      key_valid_q <= key_valid_d;
      key_press_q <= key_press_d;
    end
  end

  assign col       = col_q;
  assign data      = data_q;
  assign key_valid = key_valid_q;
  assign key_press = key_press_q;

endmodule

// File: tb/tb_kyp_scanner.sv
// Testbench for kyp_scanner with SCAN_CYCLES=4, DEBOUNCE_SCANS=2 (16-cycle frames).
// A keypad model pulls row[r] low while a pressed key's column is driven low.
// cyc counts falling edges since reset release; the column visible at cyc=k
// is (k/4)%4 and a frame result ending at cycle 16n-1 is visible at cyc=16n.
module tb_kyp_scanner;

  localparam int unsigned SC = 4;
  localparam int unsigned DB = 2;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  data;
  logic        key_valid;
  logic        key_press;

  logic [15:0] pressed = '0;   // bit r*4+c
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          press_cnt = 0;

  kyp_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .row       (row),
    .col       (col),
    .data      (data),
    .key_valid (key_valid),
    .key_press (key_press)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (key_press === 1'b1) press_cnt++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    sys_rst_n = 1'b0;
    pressed   = '0;
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    cyc       = 0;
    press_cnt = 0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    pressed   = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (col !== 4'b1110) begin n_err++; $display("FAIL reset_col got=%b exp=1110", col); end
    n_cmp++; if (data !== 4'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", data); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    n_cmp++; if (key_press !== 1'b0) begin n_err++; $display("FAIL reset_press got=%b exp=0", key_press); end
    sys_rst_n = 1'b1;
    cyc       = 0;
    press_cnt = 0;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp;
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = ~(one << ((k / 4) % 4));
      n_cmp++; if (col !== exp) begin n_err++; $display("FAIL idle_col cyc=%0d got=%b exp=%b", k, col, exp); end
    end
    run_to(64);
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got=%b exp=0", key_valid); end
    n_cmp++; if (data !== 4'h0) begin n_err++; $display("FAIL idle_data got=%h exp=0", data); end
    n_cmp++; if (press_cnt !== 0) begin n_err++; $display("FAIL idle_pulses got=%0d exp=0", press_cnt); end
  endtask

  task automatic test_key_hold_release();
    do_reset();
    pressed[5] = 1'b1;                 // key 5: r1 c1
    run_to(31);
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL k5_early_valid got=%b exp=0", key_valid); end
    tick();                            // cyc 32
    n_cmp++; if (data !== 4'h5) begin n_err++; $display("FAIL k5_data got=%h exp=5", data); end
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL k5_valid got=%b exp=1", key_valid); end
    n_cmp++; if (key_press !== 1'b1) begin n_err++; $display("FAIL k5_press got=%b exp=1", key_press); end
    tick();
    n_cmp++; if (key_press !== 1'b0) begin n_err++; $display("FAIL k5_press_width got=%b exp=0", key_press); end
    run_to(64);
    n_cmp++; if (press_cnt !== 1) begin n_err++; $display("FAIL k5_held_pulses got=%0d exp=1", press_cnt); end
    pressed[5] = 1'b0;
    run_to(95);
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL k5_rel_early got=%b exp=1", key_valid); end
    tick();                            // cyc 96
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL k5_rel_valid got=%b exp=0", key_valid); end
    n_cmp++; if (data !== 4'h5) begin n_err++; $display("FAIL k5_rel_data got=%h exp=5", data); end
    run_to(128);
    n_cmp++; if (press_cnt !== 1) begin n_err++; $display("FAIL k5_rel_pulses got=%0d exp=1", press_cnt); end
  endtask

  task automatic test_key_change();
    int drops;
    drops = 0;
    do_reset();
    pressed[15] = 1'b1;                // key D: r3 c3
    run_to(32);
    n_cmp++; if (data !== 4'hD) begin n_err++; $display("FAIL chg_data_d got=%h exp=D", data); end
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL chg_valid_d got=%b exp=1", key_valid); end
    pressed[15] = 1'b0;
    pressed[3]  = 1'b1;                // key A: r0 c3
    while (cyc < 63) begin
      tick();
      if (key_valid !== 1'b1) drops++;
    end
    n_cmp++; if (data !== 4'hD) begin n_err++; $display("FAIL chg_early_data got=%h exp=D", data); end
    tick();                            // cyc 64
    if (key_valid !== 1'b1) drops++;
    n_cmp++; if (data !== 4'hA) begin n_err++; $display("FAIL chg_data_a got=%h exp=A", data); end
    n_cmp++; if (key_press !== 1'b1) begin n_err++; $display("FAIL chg_press_a got=%b exp=1", key_press); end
    n_cmp++; if (drops !== 0) begin n_err++; $display("FAIL chg_valid_drops got=%0d exp=0", drops); end
    run_to(96);
    n_cmp++; if (press_cnt !== 2) begin n_err++; $display("FAIL chg_pulses got=%0d exp=2", press_cnt); end
    pressed = '0;
  endtask

  task automatic test_bounce();
    do_reset();
    pressed[8] = 1'b1;                 // key 7: r2 c0, present in frames 1 and 3
    run_to(16); pressed[8] = 1'b0;
    run_to(32); pressed[8] = 1'b1;
    run_to(48); pressed[8] = 1'b0;
    run_to(80);
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL bounce_valid got=%b exp=0", key_valid); end
    n_cmp++; if (press_cnt !== 0) begin n_err++; $display("FAIL bounce_pulses got=%0d exp=0", press_cnt); end
    n_cmp++; if (data !== 4'h0) begin n_err++; $display("FAIL bounce_data got=%h exp=0", data); end
    pressed[8] = 1'b1;                 // now steady from frame 6
    run_to(112);
    n_cmp++; if (data !== 4'h7) begin n_err++; $display("FAIL bounce_steady_data got=%h exp=7", data); end
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL bounce_steady_valid got=%b exp=1", key_valid); end
    pressed = '0;
  endtask

  task automatic test_multi();
    do_reset();
    pressed[0]  = 1'b1;                // key 1: r0 c0
    pressed[10] = 1'b1;                // key 9: r2 c2
    run_to(64);
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL multi_diff_valid got=%b exp=0", key_valid); end
    n_cmp++; if (press_cnt !== 0) begin n_err++; $display("FAIL multi_diff_pulses got=%0d exp=0", press_cnt); end
    pressed[10] = 1'b0;
    pressed[4]  = 1'b1;                // key 4: r1 c0, same column as key 1
    run_to(128);
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL multi_same_valid got=%b exp=0", key_valid); end
    n_cmp++; if (press_cnt !== 0) begin n_err++; $display("FAIL multi_same_pulses got=%0d exp=0", press_cnt); end
    pressed[4] = 1'b0;                 // only key 1 left
    run_to(160);
    n_cmp++; if (data !== 4'h1) begin n_err++; $display("FAIL multi_single_data got=%h exp=1", data); end

    // A MULTI frame between two key-5 frames leaves the count untouched.
    do_reset();
    pressed[5] = 1'b1;
    run_to(16); pressed[0] = 1'b1;
    run_to(32); pressed[0] = 1'b0;
    run_to(47);
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL multi_skip_early got=%b exp=0", key_valid); end
    tick();                            // cyc 48
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL multi_skip_valid got=%b exp=1", key_valid); end
    n_cmp++; if (data !== 4'h5) begin n_err++; $display("FAIL multi_skip_data got=%h exp=5", data); end
    pressed = '0;
  endtask

  task automatic test_reset_midscan();
    do_reset();
    pressed[5] = 1'b1;
    run_to(40);                        // inside COL2 of frame 3
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got=%b exp=1", key_valid); end
    n_cmp++; if (col !== 4'b1011) begin n_err++; $display("FAIL mid_pre_col got=%b exp=1011", col); end
    sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (col !== 4'b1110) begin n_err++; $display("FAIL mid_col got=%b exp=1110", col); end
    n_cmp++; if (data !== 4'h0) begin n_err++; $display("FAIL mid_data got=%h exp=0", data); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%b exp=0", key_valid); end
    pressed = '0;
    @(negedge clk);
    sys_rst_n = 1'b1;
    cyc       = 0;
    press_cnt = 0;
    run_to(3);
    n_cmp++; if (col !== 4'b1110) begin n_err++; $display("FAIL mid_restart_c0 got=%b exp=1110", col); end
    tick();
    n_cmp++; if (col !== 4'b1101) begin n_err++; $display("FAIL mid_restart_c1 got=%b exp=1101", col); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_key_hold_release();
    test_key_change();
    test_bounce();
    test_multi();
    test_reset_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kyp_scanner.md
Name: kyp_scanner

Overview:
- Scans the 4x4 PmodKYP keypad and produces the debounced 4-bit hex code consumed by the LED display path.
- Drives one column low at a time and samples the active-low rows.
- Assembles one result per full 4-column scan (a frame) and commits a key only after it is stable for a set number of consecutive frames.
- Sits between the Pmod pins and the display/consumer logic.

Parameters:
- SCAN_CYCLES, 100000, clk cycles each column stays active (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical frame results required to commit; minimum 1.

Ports:
- clk  input  1  system clock
- sys_rst_n  input  1  asynchronous, active-low reset
- row  input  4  keypad rows, active low, pulled up externally, asynchronous to clk
- col  output  4  keypad column drive, active low, exactly one bit low at all times
- data  output  4  committed key code, hex 0-F
- key_valid  output  1  high while a debounced key is held
- key_press  output  1  one-cycle pulse on each new committed key

Behaviour:
- Reset values:
  - col=4'b1110
  - data=4'h0
  - key_valid=0, key_press=0
  - internal slot counter=0, column index=0
  - frame accumulator=none, candidate=none, debounce count=0
- Input synchronisation: row passes through a 2-flop synchroniser, reset to 4'b1111. All sampling uses the synchronised value.
- Column FSM, states COL0..COL3:
  - COLc drives col[c]=0 and all other col bits=1.
  - The slot counter runs 0..SCAN_CYCLES-1.
  - On the terminal count, synced row is sampled and the FSM advances COL0->COL1->COL2->COL3->COL0.
  - col changes on the cycle after the terminal count.
- Key map (c=column index, r=row index, row[r]=0 means pressed):
  - r0: c0..c3 = 1,2,3,A
  - r1: c0..c3 = 4,5,6,B
  - r2: c0..c3 = 7,8,9,C
  - r3: c0..c3 = 0,F,E,D
- Frame classification, evaluated at the COL3 sample:
  - Zero pressed keys in the frame -> NONE.
  - Exactly one pressed key -> KEY(code).
  - Two or more pressed keys, in the same or different columns -> MULTI.
  - The accumulator clears at the start of each frame.
- Debounce, at frame end:
  - MULTI: the frame is discarded; candidate and count are unchanged.
  - Result equal to candidate: count increments, saturating at DEBOUNCE_SCANS.
  - Result different from candidate: candidate takes the result and count=1.
- Commit: occurs in the cycle after the frame end where count first reaches DEBOUNCE_SCANS.
  - KEY(k): data<=k and key_valid<=1. key_press=1 for exactly one cycle if key_valid was 0 or data!=k.
  - NONE: key_valid<=0. data holds its last value and no pulse is issued.
  - Committing the same value again produces no extra pulse. Saturation ensures one commit per stable period.
- Latency: a key held from the start of a frame commits DEBOUNCE_SCANS frames later, each frame 4*SCAN_CYCLES cycles, +1 cycle.
- Sampling window: rows must be stable for at least 3 clk before the slot's terminal count to be captured.
- Key change without release (A held, then B held): B commits after DEBOUNCE_SCANS frames of B. key_press pulses; key_valid stays 1 throughout.
- Bounce shorter than one frame resets count via candidate change, so no commit occurs.
- Reset asserted mid-scan immediately returns all state to reset values, with col=4'b1110. Scanning restarts at COL0 after deassertion.

Test Plan:
(SCAN_CYCLES=4, DEBOUNCE_SCANS=2, so 16-cycle frames)
- Idle after reset, rows=1111 -> col cycles 1110,1101,1011,0111 every 4 clk; data=0, key_valid=0, key_press never high.
- Key "5" (r1, c1) held steady -> after 2 full frames: data=4'h5, key_valid=1, one key_press pulse; no further pulses while held.
- Release "5" -> after 2 NONE frames key_valid=0; data stays 4'h5 and no pulse.
- Hold "D" (r3, c3), then switch directly to "A" (r0, c3) -> data D then A with one pulse each; key_valid stays 1.
- Key "7" bounces, present in alternating frames only -> no commit; key_valid stays 0.
- Keys "1" and "9" pressed together -> MULTI, no commit.
- Assert reset mid-COL2 while key_valid=1 -> col=1110, data=0, key_valid=0 immediately.
